fp32_divider: RTL and testbench

//  Multi-cycle IEEE754 single-precision divider, res = op1 / op2; inverse operation of the team's FP multiplier.

---
 rtl/fp32_pkg.sv | 25 ++
 rtl/fp32_divider_if.sv | 27 ++
 rtl/fp32_classify.sv | 18 +
 rtl/fp32_divider.sv | 174 +++++++++++++++++
 tb/tb_fp32_divider.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 type codes, FSM states and constants for the FP unit
package fp32_pkg;

  typedef enum logic [1:0] {
    T_NUM = 2'd0,
    T_NAN = 2'd1,
    T_ZER = 2'd2,
    T_INF = 2'd3
  } fp_type_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_SETUP = 3'd2,
    S_DIV   = 3'd3,
    S_NORM  = 3'd4,
    S_ROUND = 3'd5,
    S_PACK  = 3'd6
  } state_t;

  localparam int          FP_EXP_BIAS = 127;
  localparam logic [30:0] FP_INF_MAG  = 31'h7F800000;
  localparam logic [30:0] FP_QNAN_MAG = 31'h7FC00000;

endpackage

// File: rtl/fp32_divider_if.sv
// rtl/fp32_divider_if.sv - ready/done operand bus of the FP divider (flags with FP_DIV_FLAGS_EN)
interface fp32_divider_if;
  logic        ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] res;
  logic        done;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  modport master (
    output ready, output op1, output op2,
    input  res,   input  done
`ifdef FP_DIV_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  ready, input  op1, input  op2,
    output res,   output done
`ifdef FP_DIV_FLAGS_EN
    , output flags
`endif
  );
endinterface

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - classifies an FP32 operand as number, NaN, zero (subnormals flushed) or infinity
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] op,
  output fp_type_t    kind
);
  logic unused_sign;
  assign unused_sign = op[31];

  always_comb begin
    kind = T_NUM;
    if (op[30:23] == 8'hFF)
      kind = (op[22:0] == 23'd0) ? T_INF : T_NAN;
    else if (op[30:23] == 8'h00)
      kind = T_ZER;
  end
endmodule

// File: rtl/fp32_divider.sv
// rtl/fp32_divider.sv - multi-cycle restoring FP32 divider, res = op1 / op2
// Optional status flags are built only when FP_DIV_FLAGS_EN is defined.
module fp32_divider
  import fp32_pkg::*;
#(
  parameter logic [30:0] QNAN_MAG = FP_QNAN_MAG,
  parameter int          EXP_BIAS = FP_EXP_BIAS
) (
  input  logic           clk,
  input  logic           rst,
  fp32_divider_if.slave  bus
);
  state_t            state, state_n;
  logic              sign;
  logic [7:0]        e1, e2;
  logic [22:0]       f1, f2;
  fp_type_t          t1, t2, class_type, res_type, final_type;
  logic signed [9:0] exp_r;
  logic [24:0]       rem, rem_nxt;
  logic [25:0]       q;
  logic [4:0]        cnt;
  logic [23:0]       mant, m2;
  logic [24:0]       mant_sum;
  logic              guard, sticky, ge;
  logic [31:0]       res_r;
  logic              done_r;

  fp32_classify u_class1 (.op({1'b0, e1, f1}), .kind(t1));
  fp32_classify u_class2 (.op({1'b0, e2, f2}), .kind(t2));

  always_comb begin
    class_type = T_NUM;
    if (t1 == T_NAN || t2 == T_NAN || (t1 == T_ZER && t2 == T_ZER) || (t1 == T_INF && t2 == T_INF))
      class_type = T_NAN;
    else if (t1 == T_INF || t2 == T_ZER)
      class_type = T_INF;
    else if (t1 == T_ZER || t2 == T_INF)
      class_type = T_ZER;
  end

  // Range check happens only at PACK so NORM/ROUND adjustments are included.
  always_comb begin
    m2         = {1'b1, f2};
    ge         = (rem >= {1'b0, m2});
    rem_nxt    = ge ? (rem - {1'b0, m2}) : rem;
    mant_sum   = {1'b0, mant} + {24'd0, guard};
    final_type = res_type;
    if (res_type == T_NUM) begin
      if (exp_r <= 10'sd0)
        final_type = T_ZER;
      else if (exp_r >= 10'sd255)
        final_type = T_INF;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.ready) state_n = S_CLASS;
      S_CLASS: state_n = (class_type == T_NUM) ? S_SETUP : S_PACK;
      S_SETUP: state_n = S_DIV;
      S_DIV:   if (cnt == 5'd0) state_n = S_NORM;
      S_NORM:  state_n = S_ROUND;
      S_ROUND: state_n = S_PACK;
      S_PACK:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign     <= 1'b0;
      e1       <= 8'd0;
      e2       <= 8'd0;
      f1       <= 23'd0;
      f2       <= 23'd0;
      res_type <= T_NUM;
      exp_r    <= 10'sd0;
      rem      <= 25'd0;
      q        <= 26'd0;
      cnt      <= 5'd0;
      mant     <= 24'd0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
      res_r    <= 32'd0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.ready) begin
          sign <= bus.op1[31] ^ bus.op2[31];
          e1   <= bus.op1[30:23];
          e2   <= bus.op2[30:23];
          f1   <= bus.op1[22:0];
          f2   <= bus.op2[22:0];
        end
        S_CLASS: res_type <= class_type;
        S_SETUP: begin
          exp_r <= 10'({2'b00, e1} - {2'b00, e2} + 10'(EXP_BIAS));
          rem   <= {2'b01, f1};
          q     <= 26'd0;
          cnt   <= 5'd25;
        end
        S_DIV: begin
          q   <= {q[24:0], ge};
          rem <= {rem_nxt[23:0], 1'b0};
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        S_NORM: begin
          sticky <= (rem != 25'd0);
          if (q[25]) begin
            mant  <= q[25:2];
            guard <= q[1];
          end else begin
            mant  <= q[24:1];
            guard <= q[0];
            exp_r <= exp_r - 10'sd1;
          end
        end
        S_ROUND: begin
          if (mant_sum[24]) begin
            mant  <= 24'h800000;
            exp_r <= exp_r + 10'sd1;
          end else begin
            mant  <= mant_sum[23:0];
          end
        end
        S_PACK: begin
          done_r <= 1'b1;
          case (final_type)
            T_ZER:   res_r <= {sign, 31'd0};
            T_INF:   res_r <= {sign, FP_INF_MAG};
            T_NAN:   res_r <= {sign, QNAN_MAG};
            default: res_r <= {sign, exp_r[7:0], mant[22:0]};
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.res  = res_r;
  assign bus.done = done_r;

`ifdef FP_DIV_FLAGS_EN
  logic       div_zero;
  logic [4:0] flags_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_zero <= 1'b0;
      flags_r  <= 5'd0;
    end else begin
      if (state == S_CLASS)
        div_zero <= (t1 == T_NUM) && (t2 == T_ZER);
      if (state == S_PACK)
        flags_r <= {final_type == T_NAN,
                    div_zero,
                    (res_type == T_NUM) && (final_type == T_INF),
                    (res_type == T_NUM) && (final_type == T_ZER),
                    (res_type == T_NUM) && (guard | sticky)};
    end
  end

  assign bus.flags = flags_r;
`endif
endmodule

// File: tb/tb_fp32_divider.sv
// tb/tb_fp32_divider.sv - directed scoreboard bench for fp32_divider
module tb_fp32_divider;
  import fp32_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    int          start;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fp32_divider_if bus();
  fp32_divider dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ops = 0;
  int   last_done = 0;
  int   done_cnt = 0;
  int   wide_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (prev_done === 1'b1) wide_cnt <= wide_cnt + 1;
    end
    prev_done <= bus.done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                      input logic [4:0] f, input int lat);
    exp_t e;
    bus.op1   = a;
    bus.op2   = b;
    bus.ready = 1'b1;
    e.res   = r;
    e.flags = f;
    e.start = cyc + 1;
    e.lat   = lat;
    sb.push_back(e);
    n_ops++;
  endtask

  task automatic wait_done(input int bound);
    exp_t e;
    bit   found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) found = 1'b1;
    end
    check("done_seen", {31'd0, found}, 32'd1);
    if (found) begin
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("res", bus.res, e.res);
        check("latency", 32'(cyc - e.start), 32'(e.lat));
`ifdef FP_DIV_FLAGS_EN
        check("flags", {27'd0, bus.flags}, {27'd0, e.flags});
`endif
        last_done = cyc;
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic [4:0] f, input int lat);
    @(negedge clk);
    push(a, b, r, f, lat);
    @(negedge clk);
    bus.ready = 1'b0;
    bus.op1   = $urandom;
    bus.op2   = $urandom;
    wait_done(45);
  endtask

  initial begin
    int prev;
    int d0;
    bus.ready = 1'b0;
    bus.op1   = 32'd0;
    bus.op2   = 32'd0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_res", bus.res, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 31);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 31);
    run_op(32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 5'b00001, 31);
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 31);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2);
    run_op(32'h7FC00000, 32'hBF800000, 32'hFFC00000, 5'b10000, 2);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2);
    run_op(32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 2);
    run_op(32'h7F000000, 32'h3F000000, 32'h7F800000, 5'b00100, 31);
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 5'b00010, 31);
    run_op(32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 2);

    // abort mid-division: no done may follow and res must clear
    @(negedge clk);
    bus.op1   = 32'h40C00000;
    bus.op2   = 32'h40000000;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_res", bus.res, 32'd0);

    // back-to-back with ready held high
    @(negedge clk);
    push(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 31);
    wait_done(45);
    push(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 31);
    prev = last_done;
    wait_done(45);
    check("b2b_period1", 32'(last_done - prev), 32'd32);
    push(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 31);
    prev = last_done;
    @(negedge clk);
    bus.ready = 1'b0;
    wait_done(45);
    check("b2b_period2", 32'(last_done - prev), 32'd32);

    repeat (40) @(negedge clk);
    check("done_total", 32'(done_cnt), 32'(n_ops));
    check("done_width", 32'(wide_cnt), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
